// File: rtl/data_cache.sv
// Blocking set-associative write-through data cache with round-robin refill.
// Optional hit/miss counters are enabled with `define DATA_CACHE_STATS_EN.
module data_cache #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 17,
  parameter int SETS          = 8,
  parameter int WAYS          = 2,
  parameter int LINE_WORDS    = 4
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     RE,
  input  logic [3:0]               BE,
  input  logic [ADDRESS_WIDTH-1:0] A,
  input  logic [DATA_WIDTH-1:0]    WD,
  output logic [DATA_WIDTH-1:0]    RD,
  output logic                     Stall,
  output logic                     MemReq,
  output logic                     MemWE,
  output logic [ADDRESS_WIDTH-1:0] MemA,
  output logic [DATA_WIDTH-1:0]    MemWD,
  output logic [3:0]               MemBE,
  input  logic [DATA_WIDTH-1:0]    MemRD,
  input  logic                     MemAck
`ifdef DATA_CACHE_STATS_EN
  ,
  output logic [31:0]              HitCount,
  output logic [31:0]              MissCount
`endif
);

  localparam int OB = $clog2(LINE_WORDS);
  localparam int OW = (OB > 0) ? OB : 1;
  localparam int IB = $clog2(SETS);
  localparam int TW = ADDRESS_WIDTH - IB - OB - 2;
  localparam int WW = (WAYS > 1) ? $clog2(WAYS) : 1;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    WRITE
  } state_t;

  state_t r_state, w_next;

  logic [WAYS-1:0]       r_valid [SETS];
  logic [TW-1:0]         r_tag   [SETS][WAYS];
  logic [DATA_WIDTH-1:0] r_data  [SETS][WAYS][LINE_WORDS];
  logic [WW-1:0]         r_rr    [SETS];
  logic [OW-1:0]         r_cnt;

  logic [ADDRESS_WIDTH-3:0] w_word;
  logic [OW-1:0]            w_off;
  logic [IB-1:0]            w_idx;
  logic [TW-1:0]            w_tag;
  logic [3:0]               w_nhit;
  logic [WW-1:0]            w_hway;
  logic [WW-1:0]            w_vict;
  logic                     w_found;
  logic                     w_hit;
  logic                     w_store;
  logic                     w_load;
  logic                     w_rhit;
  logic                     w_last;
  logic [ADDRESS_WIDTH-1:0] w_line;
  logic [ADDRESS_WIDTH-1:0] w_fill_a;

  assign w_word  = A[ADDRESS_WIDTH-1:2];
  assign w_off   = (OB > 0) ? OW'(w_word) : '0;
  assign w_idx   = IB'(w_word >> OB);
  assign w_tag   = TW'(w_word >> (OB + IB));
  assign w_store = |BE;
  assign w_load  = RE && !w_store;
  assign w_last  = (r_cnt == OW'(LINE_WORDS - 1));
  assign w_line  = A & ~ADDRESS_WIDTH'(LINE_WORDS * 4 - 1);
  assign w_fill_a = w_line | (ADDRESS_WIDTH'(r_cnt) << 2);

  always_comb begin
    w_nhit = '0;
    w_hway = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (r_valid[w_idx][w] && r_tag[w_idx][w] == w_tag) begin
        w_nhit = w_nhit + 1'b1;
        w_hway = WW'(w);
      end
    end
  end

  assign w_hit = (w_nhit == 4'd1);

  // First invalid way wins; otherwise the set's round-robin pointer.
  always_comb begin
    w_vict  = r_rr[w_idx];
    w_found = 1'b0;
    for (int w = 0; w < WAYS; w++) begin
      if (!w_found && !r_valid[w_idx][w]) begin
        w_vict  = WW'(w);
        w_found = 1'b1;
      end
    end
  end

  assign w_rhit = RST && (r_state == IDLE) && w_load && w_hit;
  assign RD     = w_rhit ? r_data[w_idx][w_hway][w_off] : '0;

  always_comb begin
    w_next = r_state;
    Stall  = 1'b0;
    MemReq = 1'b0;
    MemWE  = 1'b0;
    MemA   = '0;
    MemWD  = '0;
    MemBE  = '0;
    unique case (r_state)
      IDLE: begin
        if (w_store) begin
          Stall  = 1'b1;
          w_next = WRITE;
        end else if (w_load && !w_hit) begin
          Stall  = 1'b1;
          w_next = FILL;
        end
      end
      FILL: begin
        Stall  = 1'b1;
        MemReq = 1'b1;
        MemA   = w_fill_a;
        if (MemAck && w_last) w_next = IDLE;
      end
      WRITE: begin
        Stall  = !MemAck;
        MemReq = 1'b1;
        MemWE  = 1'b1;
        MemA   = A;
        MemWD  = WD;
        MemBE  = BE;
        if (MemAck) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
    if (!RST) Stall = 1'b0;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      for (int s = 0; s < SETS; s++) begin
        r_valid[s] <= '0;
        r_rr[s]    <= '0;
      end
    end else begin
      r_state <= w_next;
      if (r_state == FILL && MemAck) begin
        r_cnt <= w_last ? '0 : r_cnt + 1'b1;
        if (w_last) begin
          r_valid[w_idx][w_vict] <= 1'b1;
          r_rr[w_idx] <= (r_rr[w_idx] == WW'(WAYS - 1)) ?
                         '0 : r_rr[w_idx] + 1'b1;
        end
      end
    end
  end

  // Tag and data arrays carry no reset; validity lives in r_valid.
  always_ff @(posedge CLK) begin
    if (RST && r_state == FILL && MemAck) begin
      r_data[w_idx][w_vict][r_cnt] <= MemRD;
      if (w_last) r_tag[w_idx][w_vict] <= w_tag;
    end
    if (RST && r_state == WRITE && MemAck && w_hit) begin
      for (int b = 0; b < 4; b++) begin
        if (BE[b]) r_data[w_idx][w_hway][w_off][8*b +: 8] <= WD[8*b +: 8];
      end
    end
  end

`ifdef DATA_CACHE_STATS_EN
  logic r_refill;

  // The hit cycle that ends a refill belongs to the miss, not a new hit.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      HitCount  <= '0;
      MissCount <= '0;
      r_refill  <= 1'b0;
    end else begin
      r_refill <= (r_state == FILL) && MemAck && w_last;
      if (w_rhit && !r_refill) HitCount <= HitCount + 32'd1;
      if (r_state == IDLE && w_next == FILL) MissCount <= MissCount + 32'd1;
    end
  end
`endif

endmodule

// File: doc/data_cache.md
DATA_CACHE -- requirements
Module: data_cache

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, the word width (fixed at 32 with 4 byte lanes).
REQ-002 SHALL have parameter ADDRESS_WIDTH, default 17, the byte-address width.
REQ-003 SHALL have parameter SETS, default 8, the number of sets (power of 2, at least 2).
REQ-004 SHALL have parameter WAYS, default 2, the associativity (1 to 8).
REQ-005 SHALL have parameter LINE_WORDS, default 4, the words per line (power of 2, at least 1).
REQ-006 SHALL have port CLK, input, 1 bit: the single clock, rising edge.
REQ-007 SHALL have port RST, input, 1 bit: asynchronous, active-low reset.
REQ-008 SHALL have port RE, input, 1 bit: load request from the M stage.
REQ-009 SHALL have port BE, input, 4 bits: store byte enables; any bit set marks a store.
REQ-010 SHALL have port A, input, ADDRESS_WIDTH bits: the byte address.
REQ-011 SHALL have port WD, input, DATA_WIDTH bits: store data, already lane-aligned.
REQ-012 SHALL have port RD, output, DATA_WIDTH bits: load data (whole word).
REQ-013 SHALL have port Stall, output, 1 bit: freezes the pipeline while high.
REQ-014 SHALL have ports MemReq (output, 1 bit), MemWE (output, 1 bit), MemA (output, ADDRESS_WIDTH bits), MemWD (output, 32 bits) and MemBE (output, 4 bits), forming the backing-memory request.
REQ-015 SHALL have ports MemRD (input, 32 bits) and MemAck (input, 1 bit): memory read data and the completion strobe.

Function
REQ-016 SHALL split A as tag | index (log2 SETS bits) | word offset (log2 LINE_WORDS bits) | byte offset (2 bits); the byte offset is ignored for lookup.
REQ-017 SHALL compare the tag with every valid way of the indexed set combinationally; hit means exactly one way matches.
REQ-018 SHALL, on a read hit in IDLE, drive RD from the hit word in the same cycle with Stall=0.
REQ-019 SHALL use FSM states IDLE, FILL and WRITE.
REQ-020 SHALL, on a read miss in IDLE, assert Stall combinationally in that cycle and enter FILL.
REQ-021 SHALL, in FILL, issue LINE_WORDS word reads to line-aligned addresses in ascending order, word 0 first.
REQ-022 SHALL, in FILL, hold each request (MemReq=1, MemWE=0, MemA stable) until MemAck, and capture MemRD on the MemAck cycle.
REQ-023 SHALL, on the last fill ack, write the line into the victim way, set its valid bit and tag, advance the set's round-robin pointer modulo WAYS, and return to IDLE.
REQ-024 SHALL choose the victim as the first invalid way, or the round-robin way if all ways are valid.
REQ-025 SHALL give a read-miss latency of LINE_WORDS memory transactions plus one cycle; Stall drops on the IDLE hit cycle.
REQ-026 SHALL treat stores as write-through, no-write-allocate: any BE bit set in IDLE enters WRITE with Stall=1.
REQ-027 SHALL, in WRITE, drive MemReq=1, MemWE=1, MemA=A and MemBE=BE until MemAck.
REQ-028 SHALL, on the WRITE ack, merge the enabled bytes into the cached word on a hit (no change on a miss) and return to IDLE with Stall=0.
REQ-029 SHALL give a store priority when RE and BE are both set; the load is then ignored.
REQ-030 SHALL require the requester to hold A, WD, RE and BE stable while Stall=1; the block does not sample them again.
REQ-031 SHALL drive RD=0 whenever there is no read hit, and MemReq=0 in IDLE.
REQ-032 SHALL treat a request with neither RE nor BE set as idle: Stall=0 and no memory traffic.

Reset
REQ-033 SHALL, when RST=0, immediately clear all valid bits and round-robin pointers, force IDLE, and drive Stall=0, MemReq=0, MemWE=0, MemA=0, MemWD=0, MemBE=0 and RD=0.
REQ-034 SHALL, when reset is asserted mid-FILL or mid-WRITE, abandon the transaction without installing a partial line; a late MemAck after reset is ignored.
REQ-035 SHALL NOT reset the tag and data arrays.

Configuration
REQ-036 SHALL, with macro DATA_CACHE_STATS_EN defined, add 32-bit outputs HitCount and MissCount. Each resets to 0, increments once per completed load (hit in IDLE without a preceding miss; miss on FILL entry), and wraps from 0xFFFFFFFF to 0.
REQ-037 SHALL, without DATA_CACHE_STATS_EN, have neither port nor the counter logic present.

Verification
REQ-038 SHALL cover: after reset, RE=1, A=0x40 with memory returning 0x11,0x22,0x33,0x44 after 2-cycle ack -> MemA 0x40,0x44,0x48,0x4C in order, Stall high 9 cycles, then RD=0x11 with Stall=0.
REQ-039 SHALL cover: after that fill, RE=1, A=0x48 -> RD=0x33 in the same cycle, Stall=0, MemReq=0.
REQ-040 SHALL cover: a store with BE=0011, WD=0x0000BEEF to 0x44 (hit) -> one MemWE request with MemBE=0011; a subsequent load of 0x44 gives RD=0x0000BEEF.
REQ-041 SHALL cover: with WAYS=2 and SETS=8, loads to 0x040, 0x240 and 0x440 (same set) -> the third fill evicts the 0x040 line; reloading 0x040 misses again.
REQ-042 SHALL cover: RST=0 pulsed during the second fill word -> MemReq falls immediately; a later load of the same address misses and refills.
REQ-043 SHALL cover, with DATA_CACHE_STATS_EN: 1 miss followed by 3 hits -> MissCount=1 and HitCount=3.
